xc_aessub_arbiter: RTL and testbench
====================================

# xc_aessub_arbiter

Round-robin arbiter sharing one `xc.aessub` SubBytes datapath between up to four requesters, e.g. the execute stage and a second issue port. Requesters submit operand pairs with encrypt/rotate flags, and the arbiter sequences each operation through the unit's valid/ready handshake. Results are routed back to the owning requester. Only one operation is in flight at a time. Per-requester flush drops pending or in-flight work without corrupting the unit handshake.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, legal range 2..4.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: request present, one bit per requester.
- `req_ready` out NREQ: request accepted this cycle; one-hot or zero.
- `req_rs1` in 32*NREQ: operand 1; requester i uses bits [32i+31:32i].
- `req_rs2` in 32*NREQ: operand 2, same packing.
- `req_enc` in NREQ: 1 = encrypt, 0 = decrypt.
- `req_rot` in NREQ: 1 = apply rotate variant.
- `flush` in NREQ: discard requester i's pending or in-flight operation.
- `rsp_valid` out NREQ: result available; one-hot or zero.
- `rsp_result` out 32: result data, shared by all requesters.
- `rsp_ready` in NREQ: requester consumes its result.
- `u_valid` out 1: operation presented to the unit.
- `u_rs1` out 32, `u_rs2` out 32, `u_enc` out 1, `u_rot` out 1: unit operands.
- `u_ready` in 1: unit completes; `u_result` is valid in this cycle.
- `u_result` in 32: unit result.
- `busy` out 1: high when the FSM is not in IDLE.

## Operation
States are IDLE, BUSY and RESP. Registers:
- `owner`: clog2(NREQ) bits, minimum 1.
- `ptr`: round-robin pointer.
- `drop`: drop flag.
- Operand registers.
- Result register.

IDLE:
- Eligible set: `req_valid[i] & ~flush[i]`.
- Grant goes to the first eligible i, scanning ptr, ptr+1, … modulo NREQ.
- On grant: `req_ready[grant]`=1 (combinational), capture operands and flags, set `owner` = grant, clear `drop`, go to BUSY.
- If no requester is eligible, stay in IDLE.

BUSY:
- `u_valid`=1 and the operand registers drive `u_*`; they stay stable until `u_ready`.
- `flush[owner]`=1 sets `drop`. The unit is never aborted; the arbiter still waits for `u_ready`.
- On `u_ready`:
  - If `drop` or `flush[owner]` is set: go to IDLE.
  - Otherwise: capture `u_result`, go to RESP.

RESP:
- `rsp_valid[owner]`=1 and `rsp_result` = result register.
- `rsp_ready[owner]` or `flush[owner]` ends the operation and returns to IDLE.

`ptr` update:
- On every return to IDLE from BUSY or RESP, `ptr` = owner+1.
- Wrap-around: NREQ-1 → 0.

Other rules:
- `flush` on a non-owner requester has no effect on the current operation.
- `rsp_ready` of a non-owner is ignored.

## Timing
Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `u_valid`=0, `u_rs1`=`u_rs2`=0, `u_enc`=`u_rot`=0, `busy`=0, `ptr`=0, state IDLE.

Latency and throughput:
- Accept happens at cycle 0.
- `u_valid` is high from cycle 1.
- With `u_ready` in cycle 1+k, `rsp_valid` is high in cycle 2+k.
- The earliest next accept is the cycle after the response is consumed. Peak throughput is one operation per 3 cycles.

Handshake and corner cases:
- In IDLE, a requester asserting `req_valid` and `flush` in the same cycle is not granted.
- Reset mid-operation returns the arbiter to IDLE immediately with all outputs at their reset values. The unit shares the same reset.

## Structure
- Package `xc_aessub_pkg` holds:
  - the state enum typedef (IDLE/BUSY/RESP);
  - the `NREQ_MAX`=4 constant;
  - the owner-index width constant.
- Sub-module `xc_rr_pick`: combinational round-robin picker with inputs `req` and `ptr`, outputs `grant_onehot`, `grant_idx` and `any`. It is parameterised by NREQ.

## Test plan
- Single request: r0 sends rs1=0x00112233, rs2=0x44556677, enc=1, rot=1. The unit stub has 0-cycle ready and returns 0xDEADBEEF. Required: `req_ready[0]` at cycle 0, `u_valid` at cycle 1, `rsp_valid[0]` with 0xDEADBEEF at cycle 2, `ptr`=1 afterwards.
- Contention: r0 and r1 both hold `req_valid` continuously for 4 operations. Required: grants alternate 0,1,0,1 with no starvation.
- Unit backpressure: the stub delays `u_ready` by 5 cycles. Required: `u_rs1`, `u_rs2`, `u_enc` and `u_rot` are stable all 5 cycles, and `rsp_valid` arrives at cycle 7.
- Flush in BUSY: flush the owner at cycle 2 while `u_ready` is delayed to cycle 4. Required: `u_valid` is held until cycle 4, no `rsp_valid` is raised, IDLE is reached at cycle 5, and the other requester is granted next.
- Response stall: hold `rsp_ready`=0 for 3 cycles. Required: `rsp_valid` and `rsp_result` stay stable, and no new grant is issued until consumption.
- Reset mid-operation: assert `reset` while in BUSY. Required: the next cycle shows `u_valid`=0, `busy`=0, `ptr`=0, and a fresh request is then served normally.

Source files
------------

// File: rtl/xc_aessub_pkg.sv
// Shared types and constants for the xc.aessub SubBytes arbiter.
package xc_aessub_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Upper bound on the number of requesters sharing the unit.
  localparam int NREQ_MAX = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Widest owner index the arbiter can ever need.
  localparam int OWNER_W = idx_width(NREQ_MAX);

endpackage

// File: rtl/xc_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module xc_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  logic [IW-1:0] sel;

  // Position k steps after base, wrapped into 0..NREQ-1 (base is always < NREQ).
  function automatic int wrap_idx(input int base, input int k);
    int s;
    s = base + k;
    if (s >= NREQ) s = s - NREQ;
    return s;
  endfunction

  // Scan farthest-to-nearest so the entry closest to ptr wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    sel          = '0;
    any          = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel = IW'(wrap_idx(int'(ptr), k));
      if (req[sel]) grant_idx = sel;
    end
    if (any) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/xc_aessub_arbiter.sv
// Round-robin arbiter sharing one xc.aessub SubBytes unit between NREQ requesters.
module xc_aessub_arbiter
  import xc_aessub_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_rs1,
  input  logic [32*NREQ-1:0] req_rs2,
  input  logic [NREQ-1:0]   req_enc,
  input  logic [NREQ-1:0]   req_rot,
  input  logic [NREQ-1:0]   flush,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_result,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              u_valid,
  output logic [31:0]       u_rs1,
  output logic [31:0]       u_rs2,
  output logic              u_enc,
  output logic              u_rot,
  input  logic              u_ready,
  input  logic [31:0]       u_result,
  output logic              busy
);

  localparam int OW = idx_width(NREQ);

  state_t          state, state_next;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   ptr;
  logic [OW-1:0]   owner_plus;
  logic            drop;
  logic [31:0]     op_rs1, op_rs2;
  logic            op_enc, op_rot;
  logic [31:0]     result;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant_onehot;
  logic [OW-1:0]   grant_idx;
  logic            grant_any;
  logic            grant_fire;
  logic            capture_result;
  logic            ret_idle;
  logic            owner_flush;
  logic            owner_rsp_ready;

  // A requester flushing in the same cycle it asks is not a candidate.
  assign eligible        = req_valid & ~flush;
  assign owner_flush     = flush[owner];
  assign owner_rsp_ready = rsp_ready[owner];
  assign owner_plus      = (int'(owner) == NREQ - 1) ? '0 : owner + OW'(1);

  xc_rr_pick #(
    .NREQ (NREQ),
    .IW   (OW)
  ) u_pick (
    .req          (eligible),
    .ptr          (ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; the unit is never aborted, so BUSY always waits for u_ready.
  always_comb begin
    state_next     = state;
    grant_fire     = 1'b0;
    capture_result = 1'b0;
    ret_idle       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          grant_fire = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (u_ready) begin
          if (drop || owner_flush) begin
            ret_idle   = 1'b1;
            state_next = IDLE;
          end else begin
            capture_result = 1'b1;
            state_next     = RESP;
          end
        end
      end
      RESP: begin
        if (owner_rsp_ready || owner_flush) begin
          ret_idle   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, ownership, drop flag, result and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner  <= '0;
      ptr    <= '0;
      drop   <= 1'b0;
      op_rs1 <= '0;
      op_rs2 <= '0;
      op_enc <= 1'b0;
      op_rot <= 1'b0;
      result <= '0;
    end else begin
      if (grant_fire) begin
        owner  <= grant_idx;
        drop   <= 1'b0;
        op_rs1 <= req_rs1[32*grant_idx +: 32];
        op_rs2 <= req_rs2[32*grant_idx +: 32];
        op_enc <= req_enc[grant_idx];
        op_rot <= req_rot[grant_idx];
      end
      if (state == BUSY && owner_flush) drop <= 1'b1;
      if (capture_result) result <= u_result;
      if (ret_idle) ptr <= owner_plus;
    end
  end

  // Response valid is steered to the owning requester only.
  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  assign req_ready  = grant_fire ? grant_onehot : '0;
  assign rsp_result = result;
  assign u_valid    = (state == BUSY);
  assign u_rs1      = op_rs1;
  assign u_rs2      = op_rs2;
  assign u_enc      = op_enc;
  assign u_rot      = op_rot;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_xc_aessub_arbiter.sv
// Directed self-checking bench for xc_aessub_arbiter with a delayable unit stub.
module tb_xc_aessub_arbiter;

  localparam int NREQ = 2;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_rs1;
  logic [32*NREQ-1:0] req_rs2;
  logic [NREQ-1:0]   req_enc;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   flush;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_result;
  logic [NREQ-1:0]   rsp_ready;
  logic              u_valid;
  logic [31:0]       u_rs1;
  logic [31:0]       u_rs2;
  logic              u_enc;
  logic              u_rot;
  logic              u_ready;
  logic [31:0]       u_result;
  logic              busy;

  int          checks;
  int          errors;
  int          stubDelay;
  int          waitCnt;
  logic [31:0] stubResult;
  int          expOwner;

  xc_aessub_arbiter #(.NREQ(NREQ)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_enc    (req_enc),
    .req_rot    (req_rot),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .u_valid    (u_valid),
    .u_rs1      (u_rs1),
    .u_rs2      (u_rs2),
    .u_enc      (u_enc),
    .u_rot      (u_rot),
    .u_ready    (u_ready),
    .u_result   (u_result),
    .busy       (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Unit stub: raises u_ready once u_valid has been held stubDelay cycles.
  always @(posedge clock) begin
    if (reset || !u_valid || u_ready) waitCnt <= 0;
    else                              waitCnt <= waitCnt + 1;
  end
  assign u_ready  = u_valid && (waitCnt == stubDelay);
  assign u_result = stubResult;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic enc, input logic rot);
    req_valid[idx]        = 1'b1;
    req_rs1[32*idx +: 32] = rs1;
    req_rs2[32*idx +: 32] = rs2;
    req_enc[idx]          = enc;
    req_rot[idx]          = rot;
  endtask

  task automatic clearInputs();
    req_valid = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    req_enc   = '0;
    req_rot   = '0;
    flush     = '0;
    rsp_ready = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    stubDelay  = 0;
    stubResult = '0;
    reset      = 1'b1;
    clearInputs();
    tick();
    tick();

    $display("[TB] reset state");
    sample();
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_result", rsp_result, 32'h0);
    checkOutput("rst_u_valid", 32'(u_valid), 32'h0);
    checkOutput("rst_u_rs1", u_rs1, 32'h0);
    checkOutput("rst_u_rs2", u_rs2, 32'h0);
    checkOutput("rst_u_flags", {30'h0, u_enc, u_rot}, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ptr", 32'(dut.ptr), 32'h0);
    tick();
    reset = 1'b0;

    $display("[TB] single request");
    stubDelay  = 0;
    stubResult = 32'hDEADBEEF;
    rsp_ready  = 2'b11;
    applyStimulus(0, 32'h00112233, 32'h44556677, 1'b1, 1'b1);
    sample();
    checkOutput("single_req_ready", 32'(req_ready), 32'h1);
    checkOutput("single_busy0", 32'(busy), 32'h0);
    tick();
    req_valid = '0;
    sample();
    checkOutput("single_u_valid", 32'(u_valid), 32'h1);
    checkOutput("single_u_rs1", u_rs1, 32'h00112233);
    checkOutput("single_u_rs2", u_rs2, 32'h44556677);
    checkOutput("single_u_flags", {30'h0, u_enc, u_rot}, 32'h3);
    checkOutput("single_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    sample();
    checkOutput("single_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("single_rsp_result", rsp_result, 32'hDEADBEEF);
    tick();
    sample();
    checkOutput("single_idle", 32'(busy), 32'h0);
    checkOutput("single_ptr", 32'(dut.ptr), 32'h1);
    tick();

    $display("[TB] contention");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp_ready = 2'b11;
    applyStimulus(0, 32'hA0A0A0A0, 32'h0000000A, 1'b1, 1'b0);
    applyStimulus(1, 32'hB1B1B1B1, 32'h0000000B, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      expOwner   = n % 2;
      stubResult = 32'h10000000 + 32'(n);
      sample();
      checkOutput($sformatf("cont%0d_grant", n), 32'(req_ready), 32'(1 << expOwner));
      tick();
      sample();
      checkOutput($sformatf("cont%0d_u_rs1", n), u_rs1, (expOwner == 1) ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
      checkOutput($sformatf("cont%0d_no_grant", n), 32'(req_ready), 32'h0);
      tick();
      sample();
      checkOutput($sformatf("cont%0d_rsp_valid", n), 32'(rsp_valid), 32'(1 << expOwner));
      checkOutput($sformatf("cont%0d_rsp_result", n), rsp_result, 32'h10000000 + 32'(n));
      tick();
    end
    clearInputs();

    $display("[TB] unit backpressure");
    stubDelay  = 5;
    stubResult = 32'h5A5A0001;
    rsp_ready  = 2'b11;
    applyStimulus(0, 32'hCAFEF00D, 32'h12345678, 1'b0, 1'b1);
    sample();
    checkOutput("bp_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    for (int c = 1; c <= 6; c++) begin
      sample();
      checkOutput($sformatf("bp_c%0d_u_valid", c), 32'(u_valid), 32'h1);
      checkOutput($sformatf("bp_c%0d_u_rs1", c), u_rs1, 32'hCAFEF00D);
      checkOutput($sformatf("bp_c%0d_u_rs2", c), u_rs2, 32'h12345678);
      checkOutput($sformatf("bp_c%0d_u_flags", c), {30'h0, u_enc, u_rot}, 32'h1);
      checkOutput($sformatf("bp_c%0d_rsp", c), 32'(rsp_valid), 32'h0);
      tick();
    end
    sample();
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("bp_rsp_result", rsp_result, 32'h5A5A0001);
    tick();

    $display("[TB] flush in busy");
    stubDelay  = 3;
    stubResult = 32'hBAD0BAD0;
    applyStimulus(1, 32'h11111111, 32'h22222222, 1'b1, 1'b0);
    sample();
    checkOutput("fl_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    sample();
    checkOutput("fl_c1_u_valid", 32'(u_valid), 32'h1);
    tick();
    flush = 2'b10;
    sample();
    checkOutput("fl_c2_u_valid", 32'(u_valid), 32'h1);
    tick();
    flush = 2'b00;
    sample();
    checkOutput("fl_c3_u_valid", 32'(u_valid), 32'h1);
    checkOutput("fl_c3_rsp", 32'(rsp_valid), 32'h0);
    tick();
    applyStimulus(0, 32'h33333333, 32'h44444444, 1'b0, 1'b0);
    applyStimulus(1, 32'h55555555, 32'h66666666, 1'b0, 1'b0);
    sample();
    checkOutput("fl_c4_u_valid", 32'(u_valid), 32'h1);
    checkOutput("fl_c4_u_ready", 32'(u_ready), 32'h1);
    checkOutput("fl_c4_no_grant", 32'(req_ready), 32'h0);
    tick();
    stubDelay  = 0;
    stubResult = 32'h0BADCAFE;
    sample();
    checkOutput("fl_c5_busy", 32'(busy), 32'h0);
    checkOutput("fl_c5_rsp", 32'(rsp_valid), 32'h0);
    checkOutput("fl_c5_grant_other", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    sample();
    checkOutput("fl_next_u_rs1", u_rs1, 32'h33333333);
    tick();
    sample();
    checkOutput("fl_next_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("fl_next_rsp_result", rsp_result, 32'h0BADCAFE);
    tick();

    $display("[TB] response stall");
    stubDelay  = 0;
    stubResult = 32'h77665544;
    rsp_ready  = 2'b00;
    applyStimulus(1, 32'h01010101, 32'h02020202, 1'b1, 1'b1);
    sample();
    checkOutput("st_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b01;
    sample();
    checkOutput("st_u_valid", 32'(u_valid), 32'h1);
    tick();
    stubResult = 32'hFFFFFFFF;
    rsp_ready  = 2'b01;
    for (int c = 0; c < 3; c++) begin
      sample();
      checkOutput($sformatf("st_c%0d_rsp_valid", c), 32'(rsp_valid), 32'h2);
      checkOutput($sformatf("st_c%0d_rsp_result", c), rsp_result, 32'h77665544);
      checkOutput($sformatf("st_c%0d_no_grant", c), 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 2'b10;
    sample();
    checkOutput("st_consume_rsp", 32'(rsp_valid), 32'h2);
    checkOutput("st_consume_no_grant", 32'(req_ready), 32'h0);
    tick();
    rsp_ready  = 2'b11;
    stubResult = 32'h99999999;
    sample();
    checkOutput("st_next_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    sample();
    checkOutput("st_next_rsp_result", rsp_result, 32'h99999999);
    tick();

    $display("[TB] reset mid-operation");
    stubDelay = 10;
    applyStimulus(1, 32'hABCDABCD, 32'hDCBADCBA, 1'b1, 1'b0);
    sample();
    checkOutput("rm_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    sample();
    checkOutput("rm_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    checkOutput("rm_u_valid", 32'(u_valid), 32'h0);
    checkOutput("rm_busy_after", 32'(busy), 32'h0);
    checkOutput("rm_ptr", 32'(dut.ptr), 32'h0);
    checkOutput("rm_u_rs1", u_rs1, 32'h0);
    checkOutput("rm_rsp_result", rsp_result, 32'h0);
    tick();
    stubDelay  = 0;
    stubResult = 32'h0F0F0F0F;
    rsp_ready  = 2'b11;
    applyStimulus(0, 32'h13572468, 32'h24681357, 1'b0, 1'b1);
    flush = 2'b01;
    sample();
    checkOutput("rm_flush_idle_no_grant", 32'(req_ready), 32'h0);
    tick();
    sample();
    checkOutput("rm_flush_idle_busy", 32'(busy), 32'h0);
    flush = 2'b00;
    #1;
    checkOutput("rm_fresh_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    sample();
    checkOutput("rm_fresh_u_rs1", u_rs1, 32'h13572468);
    tick();
    sample();
    checkOutput("rm_fresh_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("rm_fresh_rsp_result", rsp_result, 32'h0F0F0F0F);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
